ahb2apb_multi: RTL

AHB2APB_MULTI -- requirements
Module: ahb2apb_multi

---
 rtl/ahb2apb_pkg.sv | 41 ++++
 rtl/ahb2apb_strb_gen.sv | 28 ++
 rtl/ahb2apb_multi.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared encodings for the multi-slave AHB-to-APB bridge: FSM states,
// AHB transfer/size/response codes and a constant-safe clog2 helper.
package ahb2apb_pkg;

    // Bridge FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WDATA  = 3'd1;
    localparam state_t ST_SETUP  = 3'd2;
    localparam state_t ST_ACCESS = 3'd3;
    localparam state_t ST_ERR1   = 3'd4;
    localparam state_t ST_ERR2   = 3'd5;

    // AHB HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB HSIZE encodings
    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // AHB HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/ahb2apb_strb_gen.sv
// Write-strobe generator: maps transfer size and the low address bits to
// APB byte lanes. Misaligned halfword/word transfers use the aligned-down
// lanes; doubleword (and any larger size) enables every lane.
module ahb2apb_strb_gen
    import ahb2apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int LANE_BITS = clog2(DATA_WIDTH / 8)
) (
    input  logic [2:0]           hsize,
    input  logic [LANE_BITS-1:0] addr_lo,
    output logic [STRB_W-1:0]    pstrb
);

    // Lane selection by size, with the offset aligned down to the size
    always_comb begin
        pstrb = '0;
        case (hsize)
            HSIZE_BYTE:  pstrb = STRB_W'(1)  << addr_lo;
            HSIZE_HALF:  pstrb = STRB_W'(3)  << (addr_lo & ~LANE_BITS'(1));
            HSIZE_WORD:  pstrb = STRB_W'(15) << (addr_lo & ~LANE_BITS'(3));
            HSIZE_DWORD: pstrb = '1;
            default:     pstrb = '1;
        endcase
    end

endmodule

// File: rtl/ahb2apb_multi.sv
// Single-clock AHB-lite slave to multi-slave APB bridge. One transfer is in
// flight at a time; the slave is picked by an address bit-field, writes take
// an extra cycle to capture HWDATA, and slave errors, bad indices and APB
// timeouts are reported as a two-cycle AHB ERROR response.
module ahb2apb_multi
    import ahb2apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 4,
    parameter int SLV_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                          ahb_hclk,
    input  logic                          ahb_hrstn,
    input  logic                          ahb_hsel,
    input  logic [1:0]                    ahb_htrans,
    input  logic [2:0]                    ahb_hsize,
    input  logic                          ahb_hwrite,
    input  logic [ADDR_WIDTH-1:0]         ahb_haddr,
    input  logic [DATA_WIDTH-1:0]         ahb_hwdata,
    output logic                          ahb_hready,
    output logic                          ahb_hresp,
    output logic [DATA_WIDTH-1:0]         ahb_hrdata,
    output logic [NUM_SLV-1:0]            apb_psel,
    output logic                          apb_penable,
    output logic                          apb_pwrite,
    output logic [ADDR_WIDTH-1:0]         apb_paddr,
    output logic [DATA_WIDTH-1:0]         apb_pwdata,
    output logic [DATA_WIDTH/8-1:0]       apb_pstrb,
    input  logic [NUM_SLV-1:0]            apb_pready,
    input  logic [NUM_SLV-1:0]            apb_pslverr,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] apb_prdata
);

    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int LANE_BITS = clog2(STRB_W);
    localparam int IDX_BITS  = clog2(NUM_SLV);
    localparam int IDX_W     = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int CNT_W     = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

    state_t                  state_reg,   state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg,    addr_next;
    logic                    write_reg,   write_next;
    logic [2:0]              size_reg,    size_next;
    logic [IDX_W-1:0]        idx_reg,     idx_next;
    logic [CNT_W-1:0]        cnt_reg,     cnt_next;
    logic                    hready_reg,  hready_next;
    logic                    hresp_reg,   hresp_next;
    logic [DATA_WIDTH-1:0]   hrdata_reg,  hrdata_next;
    logic [NUM_SLV-1:0]      psel_reg,    psel_next;
    logic                    penable_reg, penable_next;
    logic                    pwrite_reg,  pwrite_next;
    logic [ADDR_WIDTH-1:0]   paddr_reg,   paddr_next;
    logic [DATA_WIDTH-1:0]   pwdata_reg,  pwdata_next;
    logic [STRB_W-1:0]       pstrb_reg,   pstrb_next;

    logic                    xfer_valid;
    logic [IDX_W-1:0]        idx_in;
    logic [NUM_SLV-1:0]      in_mask;
    logic [NUM_SLV-1:0]      cur_mask;
    logic [DATA_WIDTH-1:0]   rdata_slice [NUM_SLV];
    logic [DATA_WIDTH-1:0]   rdata_sel;
    logic                    pready_sel;
    logic                    pslverr_sel;
    logic [STRB_W-1:0]       wr_strb;

    // NONSEQ and SEQ start a transfer; IDLE and BUSY are ignored
    assign xfer_valid = ahb_hsel &&
                        ((ahb_htrans == HTRANS_NONSEQ) || (ahb_htrans == HTRANS_SEQ));

    // A single-slave build has no index field in the address
    generate
        if (IDX_BITS == 0) begin : g_idx_none
            assign idx_in = '0;
        end else begin : g_idx_field
            assign idx_in = ahb_haddr[SLV_LSB +: IDX_BITS];
        end
    endgenerate

    // One-hot decode of the incoming and latched index; an all-zero
    // incoming mask means the index points past the last slave
    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign in_mask[gi]     = (idx_in  == IDX_W'(gi));
            assign cur_mask[gi]    = (idx_reg == IDX_W'(gi));
            assign rdata_slice[gi] = cur_mask[gi] ?
                                     apb_prdata[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

    assign pready_sel  = |(apb_pready  & cur_mask);
    assign pslverr_sel = |(apb_pslverr & cur_mask);

    // OR-merge of the masked read-data slices of the selected slave
    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            rdata_sel = rdata_sel | rdata_slice[i];
        end
    end

    ahb2apb_strb_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_gen (
        .hsize   (size_reg),
        .addr_lo (addr_reg[LANE_BITS-1:0]),
        .pstrb   (wr_strb)
    );

    // Next-state and next-output computation; every output is registered
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        write_next   = write_reg;
        size_next    = size_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        hrdata_next  = hrdata_reg;
        psel_next    = psel_reg;
        penable_next = penable_reg;
        pwrite_next  = pwrite_reg;
        paddr_next   = paddr_reg;
        pwdata_next  = pwdata_reg;
        pstrb_next   = pstrb_reg;

        case (state_reg)
            ST_IDLE, ST_ERR2: begin
                state_next = ST_IDLE;
                if (xfer_valid) begin
                    addr_next  = ahb_haddr;
                    write_next = ahb_hwrite;
                    size_next  = ahb_hsize;
                    idx_next   = idx_in;
                    if (in_mask == '0) begin
                        state_next = ST_ERR1;
                    end else if (ahb_hwrite) begin
                        state_next = ST_WDATA;
                    end else begin
                        // Reads go straight to SETUP, so load the APB side now
                        state_next   = ST_SETUP;
                        psel_next    = in_mask;
                        penable_next = 1'b0;
                        pwrite_next  = 1'b0;
                        paddr_next   = ahb_haddr;
                        pstrb_next   = '0;
                    end
                end
            end

            ST_WDATA: begin
                state_next   = ST_SETUP;
                psel_next    = cur_mask;
                penable_next = 1'b0;
                pwrite_next  = 1'b1;
                paddr_next   = addr_reg;
                pwdata_next  = ahb_hwdata;
                pstrb_next   = wr_strb;
            end

            ST_SETUP: begin
                state_next   = ST_ACCESS;
                penable_next = 1'b1;
                cnt_next     = '0;
            end

            ST_ACCESS: begin
                if (pready_sel) begin
                    psel_next    = '0;
                    penable_next = 1'b0;
                    if (pslverr_sel) begin
                        state_next = ST_ERR1;
                    end else begin
                        state_next = ST_IDLE;
                        if (!write_reg) begin
                            hrdata_next = rdata_sel;
                        end
                    end
                end else if ((TIMEOUT > 0) && (cnt_reg == CNT_W'(TIMEOUT - 1))) begin
                    // Slave never answered: abandon the access and report an error
                    psel_next    = '0;
                    penable_next = 1'b0;
                    state_next   = ST_ERR1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_ERR1: begin
                state_next = ST_ERR2;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        hready_next = (state_next == ST_IDLE) || (state_next == ST_ERR2);
        hresp_next  = ((state_next == ST_ERR1) || (state_next == ST_ERR2)) ?
                      HRESP_ERROR : HRESP_OKAY;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge ahb_hclk) begin
        if (!ahb_hrstn) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            size_reg    <= '0;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            hready_reg  <= 1'b1;
            hresp_reg   <= HRESP_OKAY;
            hrdata_reg  <= '0;
            psel_reg    <= '0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
            pstrb_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            write_reg   <= write_next;
            size_reg    <= size_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            hready_reg  <= hready_next;
            hresp_reg   <= hresp_next;
            hrdata_reg  <= hrdata_next;
            psel_reg    <= psel_next;
            penable_reg <= penable_next;
            pwrite_reg  <= pwrite_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
            pstrb_reg   <= pstrb_next;
        end
    end

    assign ahb_hready  = hready_reg;
    assign ahb_hresp   = hresp_reg;
    assign ahb_hrdata  = hrdata_reg;
    assign apb_psel    = psel_reg;
    assign apb_penable = penable_reg;
    assign apb_pwrite  = pwrite_reg;
    assign apb_paddr   = paddr_reg;
    assign apb_pwdata  = pwdata_reg;
    assign apb_pstrb   = pstrb_reg;

endmodule
